// File: rtl/cart_arb_pkg.sv
// Shared types for the cartridge memory arbiter: FSM states, requester ids
// and the per-side pending-slot payload.
package cart_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 22;
  localparam int unsigned DATA_W     = 8;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

  typedef enum logic {
    REQ_CPU,
    REQ_PPU
  } req_id_e;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
  } slot_t;

  // Saturating byte increment used by the wait-time statistics.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cart_arb_slot.sv
// One requester's pending slot: captures an allowed request when empty (or
// being emptied on this edge) and returns read data plus a done pulse.
module cart_arb_slot
  import cart_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  allow_i,
  input  logic                  write_i,
  input  logic [DEF_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  complete_i,
  input  logic [DATA_W-1:0]     rdata_i,
  output slot_t                 slot_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  done_o
);

  slot_t             slot_q;
  slot_t             slot_d;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q;

  // Completion frees the slot before a same-edge request is considered.
  always_comb begin
    slot_d = slot_q;
    if (complete_i) begin
      slot_d.valid = 1'b0;
    end
    if (req_i && allow_i && !slot_d.valid) begin
      slot_d.valid = 1'b1;
      slot_d.write = write_i;
      slot_d.addr  = addr_i;
      slot_d.wdata = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      slot_q <= slot_d;
      done_q <= complete_i;
      if (complete_i && !slot_q.write) begin
        rdata_q <= rdata_i;
      end
    end
  end

  assign slot_o  = slot_q;
  assign rdata_o = rdata_q;
  assign done_o  = done_q;

endmodule

// File: rtl/cart_mem_arbiter.sv
// Arbitrates mapper-translated CPU (PRG) and PPU (CHR) accesses onto one
// single-port memory request/ack interface. Define CART_ARB_STATS_EN for stats.
module cart_mem_arbiter
  import cart_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned PPU_STREAK_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_write,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_allow,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  input  logic              ppu_write,
  input  logic [7:0]        ppu_wdata,
  input  logic              ppu_allow,
  output logic [7:0]        ppu_rdata,
  output logic              ppu_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
`ifdef CART_ARB_STATS_EN
  output logic [15:0]       stat_cpu_cnt,
  output logic [15:0]       stat_ppu_cnt,
  output logic [7:0]        stat_stall_max,
`endif
  input  logic              mem_ack
);

  localparam int unsigned STREAK_W = $clog2(PPU_STREAK_MAX + 2);

  arb_state_e          state_q;
  req_id_e             win_q;
  logic [STREAK_W-1:0] streak_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  slot_t cpu_slot;
  slot_t ppu_slot;
  slot_t sel_slot;
  logic  cpu_sel;
  logic  complete;
  logic  cpu_complete;
  logic  ppu_complete;

  assign complete     = (state_q == BUSY) && mem_ack;
  assign cpu_complete = complete && (win_q == REQ_CPU);
  assign ppu_complete = complete && (win_q == REQ_PPU);

  // PPU wins unless the CPU has been passed over PPU_STREAK_MAX times.
  assign cpu_sel  = cpu_slot.valid &&
                    (!ppu_slot.valid || (streak_q == STREAK_W'(PPU_STREAK_MAX)));
  assign sel_slot = cpu_sel ? cpu_slot : ppu_slot;

  cart_arb_slot u_cpu_slot (
    .clk        (clk),
    .reset      (reset),
    .req_i      (cpu_req),
    .allow_i    (cpu_allow),
    .write_i    (cpu_write),
    .addr_i     (DEF_ADDR_W'(cpu_addr)),
    .wdata_i    (cpu_wdata),
    .complete_i (cpu_complete),
    .rdata_i    (mem_rdata),
    .slot_o     (cpu_slot),
    .rdata_o    (cpu_rdata),
    .done_o     (cpu_done)
  );

  cart_arb_slot u_ppu_slot (
    .clk        (clk),
    .reset      (reset),
    .req_i      (ppu_req),
    .allow_i    (ppu_allow),
    .write_i    (ppu_write),
    .addr_i     (DEF_ADDR_W'(ppu_addr)),
    .wdata_i    (ppu_wdata),
    .complete_i (ppu_complete),
    .rdata_i    (mem_rdata),
    .slot_o     (ppu_slot),
    .rdata_o    (ppu_rdata),
    .done_o     (ppu_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= REQ_CPU;
      streak_q    <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_slot.valid || ppu_slot.valid) begin
            state_q     <= BUSY;
            win_q       <= cpu_sel ? REQ_CPU : REQ_PPU;
            mem_addr_q  <= ADDR_W'(sel_slot.addr);
            mem_rd_q    <= !sel_slot.write;
            mem_wr_q    <= sel_slot.write;
            mem_wdata_q <= sel_slot.wdata;
            if (cpu_sel) begin
              streak_q <= '0;
            end else if (cpu_slot.valid) begin
              streak_q <= streak_q + STREAK_W'(1);
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CART_ARB_STATS_EN
  logic [15:0] stat_cpu_cnt_q;
  logic [15:0] stat_ppu_cnt_q;
  logic [7:0]  stall_max_q;
  logic [7:0]  cpu_wait_q;
  logic [7:0]  ppu_wait_q;
  logic        grant;
  logic        cpu_waiting;
  logic        ppu_waiting;
  logic [7:0]  sel_wait;

  assign grant       = (state_q == IDLE) && (cpu_slot.valid || ppu_slot.valid);
  assign cpu_waiting = cpu_slot.valid && !((state_q == BUSY) && (win_q == REQ_CPU)) &&
                       !(grant && cpu_sel);
  assign ppu_waiting = ppu_slot.valid && !((state_q == BUSY) && (win_q == REQ_PPU)) &&
                       !(grant && !cpu_sel);
  assign sel_wait    = cpu_sel ? cpu_wait_q : ppu_wait_q;

  // Wait counters freeze while their request is in service.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_cnt_q <= '0;
      stat_ppu_cnt_q <= '0;
      stall_max_q    <= '0;
      cpu_wait_q     <= '0;
      ppu_wait_q     <= '0;
    end else begin
      if (cpu_complete) stat_cpu_cnt_q <= stat_cpu_cnt_q + 16'd1;
      if (ppu_complete) stat_ppu_cnt_q <= stat_ppu_cnt_q + 16'd1;
      if (grant && (sel_wait > stall_max_q)) stall_max_q <= sel_wait;
      if (!cpu_slot.valid || cpu_complete) cpu_wait_q <= '0;
      else if (cpu_waiting)                cpu_wait_q <= sat_inc8(cpu_wait_q);
      if (!ppu_slot.valid || ppu_complete) ppu_wait_q <= '0;
      else if (ppu_waiting)                ppu_wait_q <= sat_inc8(ppu_wait_q);
    end
  end

  assign stat_cpu_cnt   = stat_cpu_cnt_q;
  assign stat_ppu_cnt   = stat_ppu_cnt_q;
  assign stat_stall_max = stall_max_q;
`endif

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Scoreboard bench for cart_mem_arbiter: a transaction-level reference model
// predicts memory grants and done pulses; a negedge monitor checks the DUT.
module tb_cart_mem_arbiter;

  localparam int unsigned AW   = 22;
  localparam int unsigned SMAX = 3;
  localparam logic [AW-1:0] STREAK_CPU_ADDR = 22'h000100;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_write, cpu_allow, cpu_done;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          ppu_req, ppu_write, ppu_allow, ppu_done;
  logic [AW-1:0] ppu_addr;
  logic [7:0]    ppu_wdata, ppu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr, mem_ack;
  logic [7:0]    mem_wdata, mem_rdata;
`ifdef CART_ARB_STATS_EN
  logic [15:0]   stat_cpu_cnt, stat_ppu_cnt;
  logic [7:0]    stat_stall_max;
`endif

  cart_mem_arbiter #(.ADDR_W(AW), .PPU_STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_allow(cpu_allow), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_write(ppu_write),
    .ppu_wdata(ppu_wdata), .ppu_allow(ppu_allow), .ppu_rdata(ppu_rdata), .ppu_done(ppu_done),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef CART_ARB_STATS_EN
    .stat_cpu_cnt(stat_cpu_cnt), .stat_ppu_cnt(stat_ppu_cnt), .stat_stall_max(stat_stall_max),
`endif
    .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Bench memory contents: a fixed scramble of the address.
  function automatic logic [7:0] mem_data(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'hC3;
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    bit            wr;
    logic [7:0]    wdata;
    int            cyc;
  } mem_exp_t;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
  } done_exp_t;

  mem_exp_t  mem_q[$];
  done_exp_t cdone_q[$];
  done_exp_t pdone_q[$];

  // Reference model state: one pending request per side, one memory job.
  bit            m_cv, m_pv, m_cw, m_pw, m_busy, m_win_ppu;
  logic [AW-1:0] m_ca, m_pa;
  logic [7:0]    m_cd, m_pd;
  logic [7:0]    m_crd = '0;
  logic [7:0]    m_prd = '0;
  int            m_streak;

  always @(posedge clk) begin : model
    bit clr_c, clr_p, cpu_first;
    cyc++;
    clr_c = 1'b0;
    clr_p = 1'b0;
    if (reset) begin
      m_cv = 0; m_pv = 0; m_busy = 0; m_streak = 0;
      m_crd = '0; m_prd = '0;
      mem_q.delete(); cdone_q.delete(); pdone_q.delete();
    end else begin
      if (m_busy) begin
        if (mem_ack) begin
          if (m_win_ppu) begin
            if (!m_pw) m_prd = mem_data(m_pa);
            pdone_q.push_back('{m_prd, cyc});
            clr_p = 1'b1;
          end else begin
            if (!m_cw) m_crd = mem_data(m_ca);
            cdone_q.push_back('{m_crd, cyc});
            clr_c = 1'b1;
          end
          m_busy = 0;
        end
      end else if (m_cv || m_pv) begin
        cpu_first = m_cv && (!m_pv || m_streak >= SMAX);
        m_win_ppu = !cpu_first;
        if (cpu_first) begin
          mem_q.push_back('{m_ca, m_cw, m_cd, cyc});
          m_streak = 0;
        end else begin
          mem_q.push_back('{m_pa, m_pw, m_pd, cyc});
          if (m_cv) m_streak++;
        end
        m_busy = 1;
      end
      if (clr_c) m_cv = 0;
      if (clr_p) m_pv = 0;
      if (cpu_req && cpu_allow && !m_cv) begin
        m_cv = 1; m_ca = cpu_addr; m_cw = cpu_write; m_cd = cpu_wdata;
      end
      if (ppu_req && ppu_allow && !m_pv) begin
        m_pv = 1; m_pa = ppu_addr; m_pw = ppu_write; m_pd = ppu_wdata;
      end
    end
  end

  // Memory responder: random ack latency, optional hold and stray ack.
  bit hold_ack = 0;
  bit late_ack = 0;
  int ack_wait = 0;

  always @(negedge clk) begin : responder
    if (mem_rd || mem_wr) begin
      if (hold_ack) begin
        mem_ack = 1'b0;
      end else if (ack_wait == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_data(mem_addr);
        ack_wait  = $urandom_range(0, 3);
      end else begin
        mem_ack = 1'b0;
        ack_wait--;
      end
    end else begin
      mem_ack   = late_ack;
      mem_rdata = 8'($urandom);
    end
  end

  // Monitor: pops expectations whenever the DUT starts a job or pulses done.
  bit            mon_en = 0;
  bit            streak_watch = 0;
  bit            txn_open = 0;
  bit            cpu_seen = 0;
  int            txn_count = 0;
  int            done_count = 0;
  int            ppu_run = 0;
  int            ppu_before = -1;
  logic [AW-1:0] txn_log[$];

  always @(negedge clk) begin : monitor
    mem_exp_t  me;
    done_exp_t de;
    if (!streak_watch) begin
      ppu_run  = 0;
      cpu_seen = 0;
    end
    if (mon_en) begin
      check("mem_active", 32'(mem_rd | mem_wr), 32'(m_busy));
      if (mem_rd && mem_wr) fail("mem_rd_and_wr");
      if ((mem_rd || mem_wr) && !txn_open) begin
        txn_count++;
        txn_log.push_back(mem_addr);
        if (streak_watch && !cpu_seen) begin
          if (mem_addr == STREAK_CPU_ADDR) begin
            cpu_seen   = 1;
            ppu_before = ppu_run;
          end else begin
            ppu_run++;
          end
        end
        if (mem_q.size() == 0) begin
          fail("unexpected_mem_job");
        end else begin
          me = mem_q.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(me.addr));
          check("mem_wr", 32'(mem_wr), 32'(me.wr));
          if (me.wr) check("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
          check("grant_cycle", 32'(cyc), 32'(me.cyc));
        end
      end
      txn_open = mem_rd || mem_wr;
      if (cpu_done) begin
        done_count++;
        if (cdone_q.size() == 0) begin
          fail("unexpected_cpu_done");
        end else begin
          de = cdone_q.pop_front();
          check("cpu_done_rdata", 32'(cpu_rdata), 32'(de.rdata));
          check("cpu_done_cycle", 32'(cyc), 32'(de.cyc));
        end
      end
      if (ppu_done) begin
        done_count++;
        if (pdone_q.size() == 0) begin
          fail("unexpected_ppu_done");
        end else begin
          de = pdone_q.pop_front();
          check("ppu_done_rdata", 32'(ppu_rdata), 32'(de.rdata));
          check("ppu_done_cycle", 32'(cyc), 32'(de.cyc));
        end
      end
      check("cpu_rdata_hold", 32'(cpu_rdata), 32'(m_crd));
      check("ppu_rdata_hold", 32'(ppu_rdata), 32'(m_prd));
    end
  end

  task automatic cpu_op(input logic [AW-1:0] a, input bit wr, input logic [7:0] wd, input bit al);
    cpu_req = 1'b1; cpu_addr = a; cpu_write = wr; cpu_wdata = wd; cpu_allow = al;
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  task automatic ppu_op(input logic [AW-1:0] a, input bit wr, input logic [7:0] wd, input bit al);
    ppu_req = 1'b1; ppu_addr = a; ppu_write = wr; ppu_wdata = wd; ppu_allow = al;
    @(negedge clk);
    ppu_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((m_busy || m_cv || m_pv || mem_q.size() != 0 || cdone_q.size() != 0 ||
            pdone_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail({tag, "_idle_timeout"});
    @(negedge clk);
  endtask

  initial begin : stimulus
    int n0, d0, n;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    cpu_req = 0; cpu_addr = '0; cpu_write = 0; cpu_wdata = '0; cpu_allow = 0;
    ppu_req = 0; ppu_addr = '0; ppu_write = 0; ppu_wdata = '0; ppu_allow = 0;
    repeat (3) @(negedge clk);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    check("rst_cpu_done",  32'(cpu_done),  32'h0);
    check("rst_ppu_rdata", 32'(ppu_rdata), 32'h0);
    check("rst_ppu_done",  32'(ppu_done),  32'h0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_rd",    32'(mem_rd),    32'h0);
    check("rst_mem_wr",    32'(mem_wr),    32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    reset = 1'b0;
    mon_en = 1;
    @(negedge clk);

    // Single CPU read.
    cpu_op(22'h004010, 0, 8'h00, 1);
    wait_idle("t1");
    check("t1_cpu_rdata", 32'(cpu_rdata), 32'(mem_data(22'h004010)));
    check("t1_mem_addr", 32'(mem_addr), 32'h004010);

    // Disallowed request is dropped.
    n0 = txn_count; d0 = done_count;
    cpu_op(22'h001234, 0, 8'h00, 0);
    repeat (5) @(negedge clk);
    check("t2_no_mem_job", 32'(txn_count), 32'(n0));
    check("t2_no_done", 32'(done_count), 32'(d0));
    check("t2_rdata_kept", 32'(cpu_rdata), 32'(mem_data(22'h004010)));

    // Simultaneous requests: PPU first, then CPU.
    n0 = txn_count; d0 = done_count;
    cpu_req = 1; cpu_addr = 22'h000100; cpu_write = 0; cpu_allow = 1;
    ppu_req = 1; ppu_addr = 22'h200020; ppu_write = 0; ppu_allow = 1;
    @(negedge clk);
    cpu_req = 0; ppu_req = 0;
    wait_idle("t3");
    if (txn_log.size() >= n0 + 2) begin
      check("t3_first_ppu", 32'(txn_log[n0]), 32'h200020);
      check("t3_second_cpu", 32'(txn_log[n0 + 1]), 32'h000100);
    end else begin
      fail("t3_missing_jobs");
    end
    check("t3_done_pulses", 32'(done_count - d0), 32'd2);

    // PPU keeps requesting; CPU must win after the streak limit.
    streak_watch = 1;
    cpu_req = 1; cpu_addr = STREAK_CPU_ADDR; cpu_write = 0; cpu_allow = 1;
    ppu_req = 1; ppu_addr = 22'h200040; ppu_write = 0; ppu_allow = 1;
    @(negedge clk);
    cpu_req = 0;
    n = 0;
    while (!cpu_seen && n < 100) begin
      @(negedge clk);
      n++;
    end
    ppu_req = 0;
    check("t4_cpu_granted", 32'(cpu_seen), 32'd1);
    check("t4_ppu_grants_before_cpu", 32'(ppu_before), 32'(SMAX));
    wait_idle("t4");
    streak_watch = 0;

    // PPU write leaves ppu_rdata alone.
    n0 = txn_count;
    ppu_op(22'h200005, 1, 8'h3C, 1);
    wait_idle("t5");
    check("t5_ppu_rdata_kept", 32'(ppu_rdata), 32'(mem_data(22'h200040)));
    check("t5_mem_wdata", 32'(mem_wdata), 32'h3C);
    check("t5_one_job", 32'(txn_count - n0), 32'd1);

    // Reset while BUSY, then a stray ack.
    hold_ack = 1;
    cpu_op(22'h0000AA, 0, 8'h00, 1);
    n = 0;
    while (!mem_rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_rd) fail("t6_no_mem_rd");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; hold_ack = 0; late_ack = 1;
    check("t6_mem_rd_dropped", 32'(mem_rd), 32'h0);
    check("t6_mem_wr_low", 32'(mem_wr), 32'h0);
    n0 = txn_count; d0 = done_count;
    @(negedge clk);
    late_ack = 0;
    repeat (4) @(negedge clk);
    check("t6_no_done", 32'(done_count), 32'(d0));
    check("t6_no_new_job", 32'(txn_count), 32'(n0));
    check("t6_cpu_rdata_cleared", 32'(cpu_rdata), 32'h0);

    // Randomized traffic, including requests that hit a full slot.
    for (int i = 0; i < 3000; i++) begin
      cpu_req   = ($urandom % 100) < 25;
      cpu_allow = ($urandom % 100) < 85;
      cpu_write = ($urandom % 4) == 0;
      cpu_addr  = AW'($urandom);
      cpu_wdata = 8'($urandom);
      ppu_req   = ($urandom % 100) < 40;
      ppu_allow = ($urandom % 100) < 85;
      ppu_write = ($urandom % 4) == 0;
      ppu_addr  = AW'($urandom);
      ppu_wdata = 8'($urandom);
      @(negedge clk);
    end
    cpu_req = 0; ppu_req = 0;
    wait_idle("rand");
    check("end_mem_q_empty", 32'(mem_q.size()), 32'd0);
    check("end_cpu_q_empty", 32'(cdone_q.size()), 32'd0);
    check("end_ppu_q_empty", 32'(pdone_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
